// File: rtl/aes_round_engine_if.sv
// Block handshake and round-key fetch bundle for the iterative AES engine.
// The engine takes the slave side; the feeder/key RAM side takes master.
interface aes_round_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic         in_decrypt;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic         busy;

   modport master (
      output in_valid, in_block, in_decrypt, rk_data, out_ready,
      input  in_ready, rk_idx, out_valid, out_block, busy
   );

   modport slave (
      input  in_valid, in_block, in_decrypt, rk_data, out_ready,
      output in_ready, rk_idx, out_valid, out_block, busy
   );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 cipher and inverse cipher with SBOX_LANES byte
// substitutions per cycle; round keys are fetched by index from an external RAM.
module aes_round_engine #(
   parameter int NR         = 14,
   parameter int SBOX_LANES = 1
) (
   input  logic                clk,
   input  logic                rst,
   aes_round_engine_if.slave   bus
);

   localparam int         S         = 16 / SBOX_LANES;
   localparam logic [3:0] NR_IDX    = 4'(NR);
   localparam logic [3:0] LAST_STEP = 4'(S - 1);

   if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_round_engine: NR must be 10, 12 or 14");
   end
   if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
         SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
      $error("aes_round_engine: SBOX_LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [2:0] {IDLE, ARK, SUB, SHIFT, MIX, DONE} fsm_t;

   // ---------------------------------------------------------------- GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254; zero maps to zero as SubBytes requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a6   = gf_mul(a3, a3);
      a12  = gf_mul(a6, a6);
      a15  = gf_mul(a12, a3);
      a30  = gf_mul(a15, a15);
      a60  = gf_mul(a30, a30);
      a120 = gf_mul(a60, a60);
      a240 = gf_mul(a120, a120);
      return gf_mul(gf_mul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] v;
      v = gf_inv(x);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] mix_fwd(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul(8'h02, a0) ^ gf_mul(8'h03, a1) ^ a2 ^ a3,
              a0 ^ gf_mul(8'h02, a1) ^ gf_mul(8'h03, a2) ^ a3,
              a0 ^ a1 ^ gf_mul(8'h02, a2) ^ gf_mul(8'h03, a3),
              gf_mul(8'h03, a0) ^ a1 ^ a2 ^ gf_mul(8'h02, a3)};
   endfunction

   function automatic logic [31:0] mix_inv(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
              gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
              gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
              gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
   endfunction

   // ---------------------------------------------------------------- state
   fsm_t         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [3:0]   byte_cnt_q, byte_cnt_d;
   logic         mode_q, mode_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q, busy_d;

   logic [7:0]   st_byte  [16];
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [3:0]   lane_idx [SBOX_LANES];
   logic [7:0]   lane_out [SBOX_LANES];

   // Byte 4c+r sits at row r of column c; shift rows rotates each row by r.
   for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int ROW     = gi % 4;
      localparam int COL     = gi / 4;
      localparam int SRC_FWD = 4 * ((COL + ROW) % 4) + ROW;
      localparam int SRC_INV = 4 * ((COL + 4 - ROW) % 4) + ROW;
      assign st_byte[gi]                = state_q[127 - 8*gi -: 8];
      assign shifted[127 - 8*gi -: 8]   = mode_q ? st_byte[SRC_INV] : st_byte[SRC_FWD];
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      assign mixed[127 - 32*gi -: 32] = mode_q ? mix_inv(state_q[127 - 32*gi -: 32])
                                               : mix_fwd(state_q[127 - 32*gi -: 32]);
   end

   for (genvar gi = 0; gi < SBOX_LANES; gi++) begin : g_lanes
      assign lane_idx[gi] = 4'(int'(byte_cnt_q) * SBOX_LANES + gi);
      assign lane_out[gi] = mode_q ? sbox_inv(st_byte[lane_idx[gi]])
                                   : sbox_fwd(st_byte[lane_idx[gi]]);
   end

   always_comb begin
      fsm_d      = fsm_q;
      state_d    = state_q;
      round_d    = round_q;
      byte_cnt_d = byte_cnt_q;
      mode_d     = mode_q;
      case (fsm_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = bus.in_block;
               mode_d  = bus.in_decrypt;
               round_d = bus.in_decrypt ? NR_IDX : 4'd0;
               fsm_d   = ARK;
            end
         end
         ARK: begin
            state_d = state_q ^ bus.rk_data;
            if (mode_q) begin
               if (round_q == 4'd0) begin
                  fsm_d = DONE;
               end else if (round_q == NR_IDX) begin
                  fsm_d   = SHIFT;
                  round_d = round_q - 4'd1;
               end else begin
                  fsm_d = MIX;
               end
            end else if (round_q == NR_IDX) begin
               fsm_d = DONE;
            end else begin
               fsm_d   = SUB;
               round_d = round_q + 4'd1;
            end
         end
         SUB: begin
            for (int i = 0; i < SBOX_LANES; i++) begin
               state_d[127 - 8*int'(lane_idx[i]) -: 8] = lane_out[i];
            end
            if (byte_cnt_q == LAST_STEP) begin
               byte_cnt_d = 4'd0;
               fsm_d      = mode_q ? ARK : SHIFT;
            end else begin
               byte_cnt_d = byte_cnt_q + 4'd1;
            end
         end
         SHIFT: begin
            state_d = shifted;
            if (mode_q)                  fsm_d = SUB;
            else if (round_q == NR_IDX)  fsm_d = ARK;
            else                         fsm_d = MIX;
         end
         MIX: begin
            state_d = mixed;
            if (mode_q) begin
               fsm_d   = SHIFT;
               round_d = round_q - 4'd1;
            end else begin
               fsm_d = ARK;
            end
         end
         DONE: begin
            if (bus.out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase

      // Handshake flags are registered copies of the next FSM state.
      in_ready_d  = (fsm_d == IDLE);
      out_valid_d = (fsm_d == DONE);
      busy_d      = (fsm_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         round_q     <= '0;
         byte_cnt_q  <= '0;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         round_q     <= round_d;
         byte_cnt_q  <= byte_cnt_d;
         mode_q      <= mode_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.out_block = state_q;
   assign bus.rk_idx    = round_q;

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
Parametrised iterative AES cipher/inverse-cipher datapath with its own control FSM. It succeeds the externally sequenced 256-bit round datapath: it generalises key length (AES-128/192/256), SubBytes throughput (lanes per cycle) and per-block direction. It adds valid/ready block handshakes and a round-key fetch port. It sits between the CTR counter/keystream logic and an external key-expansion RAM, and reuses the existing SubBytes, shift_rows and mix_columns leaf modules.

Parameters:
NR, 14, number of rounds; legal values 10, 12, 14; any other value is an elaboration error.
SBOX_LANES, 1, SubBytes instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
S (localparam), 16/SBOX_LANES, SubBytes cycles per round.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input block valid
in_ready  out  1  engine can accept a block
in_block  in  128  plaintext (encrypt) or ciphertext (decrypt); byte 0 = bits [127:120]
in_decrypt  in  1  0 = cipher, 1 = inverse cipher; sampled on accept
rk_idx  out  4  index of round key required this cycle (0..NR)
rk_data  in  128  round key rk_idx, valid combinationally in the same cycle
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_block  out  128  result block; equals the internal state register
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: FSM to IDLE; state register, round counter, byte counter and mode flag clear to 0. After reset: in_ready=1, out_valid=0, busy=0, out_block=0, rk_idx=0. Reset in any state aborts the block in flight; no partial result is presented.
- Column c of the state is bits [127-32c -: 32]. Byte b is bits [127-8b -: 8].
- FSM states: IDLE, ARK, SUB, SHIFT, MIX, DONE.
- IDLE: in_ready=1. When in_valid is high: load state<=in_block, latch mode<=in_decrypt, round<=0 (encrypt) or NR (decrypt), then go to ARK.
- Encrypt sequence:
  - ARK(rk 0) first.
  - Each round r=1..NR: SUB, SHIFT, MIX (skipped when r==NR), then ARK(rk r).
- Decrypt sequence (FIPS-197 inverse cipher):
  - ARK(rk NR) first.
  - Each round r=NR-1..0: SHIFT (inverse), SUB (inverse), ARK(rk r), then MIX (inverse; skipped after rk 0).
- rk_idx equals the round counter in every state. The counter updates on exit from ARK (encrypt, +1) or on entry to SHIFT (decrypt, -1).
- SUB: S cycles. Cycle k replaces bytes k*SBOX_LANES .. k*SBOX_LANES+SBOX_LANES-1; the byte counter wraps to 0 on exit.
- SHIFT and MIX: 1 cycle each. MIX uses four mix_columns instances, all columns in parallel.
- ARK: 1 cycle; state<=state^rk_data.
- Latency: the accept edge is edge 0. out_valid rises after edge NR*(S+3) for both directions.
  - NR=14, SBOX_LANES=1: 266 cycles.
  - NR=10, SBOX_LANES=16: 40 cycles.
- DONE: out_valid=1 and out_block stable until out_ready is high. On the out_ready edge go to IDLE; in_ready stays 0 during that cycle. Maximum throughput is one block per NR*(S+3)+2 cycles.
- in_block and in_decrypt are ignored while busy. rk_data is only consumed in ARK.
- out_ready held high before DONE has no effect.
- Direction is per-block: consecutive blocks may alternate mode without reset.

Test Plan:
1. NR=14, SBOX_LANES=1. Encrypt 00112233445566778899aabbccddeeff with rk from key 000102…1f -> out_block 8ea2b7ca516745bfeafc49904b496089; out_valid first high exactly 266 cycles after accept.
2. Same configuration, decrypt 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff. The rk_idx trace must read 14, 13, …, 0 in ARK cycles.
3. NR=10, SBOX_LANES=16. Encrypt the same plaintext with key 000102…0f -> 69c4e0d86a7b0430d8cdb78070b4c55a at 40 cycles. Repeat for NR=12, SBOX_LANES=4 with key 000102…17 -> dda97ca4864cdfe06eaf70a0ec0d7191.
4. Backpressure: hold out_ready=0 for 50 cycles after DONE.
   - out_valid and out_block stay constant.
   - in_ready stays 0.
   - in_valid pulses are ignored.
   - Releasing out_ready gives IDLE next cycle.
5. Reset mid-operation: assert rst for 1 cycle during round 5 SUB -> next cycle in_ready=1, out_valid=0, out_block=0. A following block then encrypts correctly.
6. Back-to-back alternating encrypt/decrypt blocks with in_valid held high -> each result correct, and each accept occurs only in an IDLE cycle.
